// File: rtl/nixie_scan_ctrl.sv
// Scan controller for a multiplexed 7-segment bank: one digit at a time,
// each slot opens with an all-dark blanking gap, and a fresh snapshot of the inputs is taken every frame.
module nixie_scan_ctrl #(
    parameter int N_DIGITS = 4,
    parameter int DIV      = 50000,
    parameter int BLANK    = 500
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [3*N_DIGITS-1:0]   digits_i,
    input  logic [N_DIGITS-1:0]     blank_mask_i,
    output logic [2:0]              code_o,
    output logic [N_DIGITS-1:0]     dig_sel_n_o,
    output logic                    frame_start_o
);

    localparam int CNT_W = $clog2(DIV);
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK - 1);
    localparam logic [CNT_W-1:0] SHOW_END  = CNT_W'(DIV - BLANK - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_DIGITS - 1);

    generate
        if (N_DIGITS < 1 || N_DIGITS > 16 || BLANK < 1 || DIV <= BLANK) begin : g_param_check
            $error("nixie_scan_ctrl: illegal N_DIGITS/DIV/BLANK combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_BLANK,
        S_SHOW
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [3*N_DIGITS-1:0]   sh_digits_q;
    logic [N_DIGITS-1:0]     sh_mask_q;
    logic                    capture;
    logic [2:0]              code_d;
    logic [N_DIGITS-1:0]     sel_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (en) begin
                    state_d = S_BLANK;
                    idx_d   = '0;
                    cnt_d   = '0;
                    capture = 1'b1;
                end
            end
            S_BLANK: begin
                if (!en) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else if (cnt_q == BLANK_END) begin
                    state_d = S_SHOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SHOW: begin
                if (!en) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else if (cnt_q == SHOW_END) begin
                    state_d = S_BLANK;
                    cnt_d   = '0;
                    // Wrapping back to digit 0 is the frame boundary
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        capture = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
                cnt_d   = '0;
            end
        endcase

        // Outputs are decoded from the next state so they register alongside it
        code_d = '0;
        sel_d  = '1;
        if (state_d == S_SHOW) begin
            for (int k = 0; k < N_DIGITS; k++) begin
                if (idx_d == IDX_W'(k)) begin
                    code_d   = sh_digits_q[3*k +: 3];
                    sel_d[k] = sh_mask_q[k];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            cnt_q         <= '0;
            sh_digits_q   <= '0;
            sh_mask_q     <= '0;
            code_o        <= '0;
            dig_sel_n_o   <= '1;
            frame_start_o <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            code_o        <= code_d;
            dig_sel_n_o   <= sel_d;
            frame_start_o <= capture;
            if (capture) begin
                sh_digits_q <= digits_i;
                sh_mask_q   <= blank_mask_i;
            end
        end
    end

endmodule

// File: tb/tb_nixie_scan_ctrl.sv
// Directed bench for nixie_scan_ctrl with N_DIGITS=4, DIV=8, BLANK=2.
module tb_nixie_scan_ctrl;

    localparam int N = 4;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic [11:0]   digits;
    logic [3:0]    mask;
    logic [2:0]    code;
    logic [3:0]    sel_n;
    logic          fs;

    int n_cmp  = 0;
    int n_fail = 0;

    nixie_scan_ctrl #(.N_DIGITS(N), .DIV(8), .BLANK(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .digits_i      (digits),
        .blank_mask_i  (mask),
        .code_o        (code),
        .dig_sel_n_o   (sel_n),
        .frame_start_o (fs)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        en;
        logic [11:0] digits;
        logic [3:0]  mask;
        logic [2:0]  exp_code;
        logic [3:0]  exp_sel;
        logic        exp_fs;
    } vec_t;

    localparam int NV = 97;
    vec_t vecs [NV];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string nm, input logic [3:0] e_sel, input logic [2:0] e_code, input logic e_fs);
        chk({nm, ".sel"}, 32'(sel_n), 32'(e_sel));
        chk({nm, ".code"}, 32'(code), 32'(e_code));
        chk({nm, ".fs"}, 32'(fs), 32'(e_fs));
    endtask

    initial begin
        logic [11:0] d0, d1, shown;
        logic [3:0]  shown_mask;
        int          p, s, q, f, n;
        bit          seen;

        // Frame 0 shows d0; digit 1 is changed to 6 mid-frame and appears in frame 1.
        // The mask set mid-frame 1 takes effect in frame 2.
        d0 = {3'd3, 3'd2, 3'd1, 3'd0};
        d1 = {3'd3, 3'd2, 3'd6, 3'd0};
        for (int v = 0; v < NV; v++) begin
            f = v / 32;
            p = v % 32;
            s = p / 8;
            q = p % 8;
            shown      = (f == 0) ? d0 : d1;
            shown_mask = (f == 2) ? 4'b0100 : 4'b0000;
            vecs[v].en     = 1'b1;
            vecs[v].digits = (v < 4) ? d0 : d1;
            vecs[v].mask   = (v < 40) ? 4'b0000 : 4'b0100;
            vecs[v].exp_fs = (p == 0);
            if (q < 2) begin
                vecs[v].exp_sel  = 4'b1111;
                vecs[v].exp_code = 3'd0;
            end else begin
                vecs[v].exp_sel  = shown_mask[s] ? 4'b1111 : ~(4'b0001 << s);
                vecs[v].exp_code = shown[3*s +: 3];
            end
        end

        // Async reset takes effect with no clock edge
        rst_n  = 1'b1;
        en     = 1'b0;
        digits = d0;
        mask   = 4'b0000;
        #2 rst_n = 1'b0;
        #1;
        chk_out("reset_async", 4'b1111, 3'd0, 1'b0);
        step();
        step();
        #3 rst_n = 1'b1;
        step();
        chk_out("idle_en0", 4'b1111, 3'd0, 1'b0);

        // Startup, wrap, mid-frame change, masking
        for (int v = 0; v < NV; v++) begin
            en     = vecs[v].en;
            digits = vecs[v].digits;
            mask   = vecs[v].mask;
            step();
            chk_out($sformatf("vec%0d", v), vecs[v].exp_sel, vecs[v].exp_code, vecs[v].exp_fs);
        end

        // Disable during digit-1 SHOW (frame position 11)
        for (int i = 1; i <= 11; i++) step();
        chk_out("dig1_show", 4'b1101, 3'd6, 1'b0);
        en = 1'b0;
        step();
        chk_out("disable_edge", 4'b1111, 3'd0, 1'b0);
        step();
        chk_out("disable_hold", 4'b1111, 3'd0, 1'b0);

        // Re-enable restarts at digit 0 with a fresh snapshot
        en     = 1'b1;
        digits = d0;
        mask   = 4'b0000;
        step();
        chk_out("reen_fs", 4'b1111, 3'd0, 1'b1);
        step();
        chk_out("reen_blank2", 4'b1111, 3'd0, 1'b0);
        step();
        chk_out("reen_show0", 4'b1110, 3'd0, 1'b0);

        // Async reset pulse between edges during SHOW
        step();
        #2 rst_n = 1'b0;
        #1;
        chk_out("midshow_reset", 4'b1111, 3'd0, 1'b0);
        #1 rst_n = 1'b1;
        step();
        chk_out("post_reset_fs", 4'b1111, 3'd0, 1'b1);

        // Bounded wait for the next frame pulse; must be 32 cycles later
        seen = 1'b0;
        n    = 0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            step();
            if (i == 2) chk_out("post_reset_show0", 4'b1110, 3'd0, 1'b0);
            if (i == 10) chk_out("post_reset_show1", 4'b1101, 3'd1, 1'b0);
            if (fs) begin
                seen = 1'b1;
                n    = i;
            end
        end
        chk("post_reset_period", 32'(n), 32'd32);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
